// File: rtl/simple_processor_core_if.sv
// Memory-side bus of simple_processor_core: one instruction read port and
// one data read/write port, each a request/ack pair.
interface simple_processor_core_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_ack;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/simple_processor_core.sv
// Multi-cycle 32-bit core with 16-bit instructions: FETCH -> EXEC -> (MEM) -> FETCH,
// 16 GPRs with r0 hard-wired to zero.
module simple_processor_core #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [ADDR_WIDTH-1:0] boot_addr_i,
    simple_processor_core_if.master mem
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SLT  = 4'h7,
        OP_LI   = 4'h8, OP_ADDI = 4'h9, OP_LW   = 4'hA, OP_SW   = 4'hB,
        OP_BEQ  = 4'hC, OP_BNE  = 4'hD, OP_JALR = 4'hE, OP_NOP  = 4'hF
    } opcode_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           ir_q;
    logic [DATA_WIDTH-1:0] rf_q [16];

    logic                  dwe_q;
    logic [ADDR_WIDTH-1:0] daddr_q;
    logic [DATA_WIDTH-1:0] dwdata_q;

    logic                  ir_load;
    logic                  mem_load;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wdata;

    // Instruction fields and operands; rf_q[0] is never written, so r0 reads 0.
    opcode_e               op;
    logic [3:0]            rd, rs1, rs2;
    logic [DATA_WIDTH-1:0] rd_val, rs1_val, rs2_val, imm_sext, eff_addr;
    logic [ADDR_WIDTH-1:0] pc_inc, br_off;
    logic [15:0]           fetch_half;

    assign op       = opcode_e'(ir_q[15:12]);
    assign rd       = ir_q[11:8];
    assign rs1      = ir_q[7:4];
    assign rs2      = ir_q[3:0];
    assign rd_val   = rf_q[rd];
    assign rs1_val  = rf_q[rs1];
    assign rs2_val  = rf_q[rs2];
    assign imm_sext = {{(DATA_WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    assign eff_addr = rs1_val + (rs2_val << 2);
    assign pc_inc   = pc_q + ADDR_WIDTH'(2);
    assign br_off   = {{(ADDR_WIDTH-5){rs2[3]}}, rs2, 1'b0};

    assign fetch_half = pc_q[1] ? mem.imem_rdata[31:16] : mem.imem_rdata[15:0];

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_load  = 1'b0;
        mem_load = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = '0;

        case (state_q)
            ST_FETCH: begin
                if (mem.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                rf_we   = 1'b1;
                case (op)
                    OP_ADD:  rf_wdata = rs1_val + rs2_val;
                    OP_SUB:  rf_wdata = rs1_val - rs2_val;
                    OP_AND:  rf_wdata = rs1_val & rs2_val;
                    OP_OR:   rf_wdata = rs1_val | rs2_val;
                    OP_XOR:  rf_wdata = rs1_val ^ rs2_val;
                    OP_SLL:  rf_wdata = rs1_val << rs2_val[4:0];
                    OP_SRL:  rf_wdata = rs1_val >> rs2_val[4:0];
                    OP_SLT:  rf_wdata = {{(DATA_WIDTH-1){1'b0}},
                                         ($signed(rs1_val) < $signed(rs2_val))};
                    OP_LI:   rf_wdata = imm_sext;
                    OP_ADDI: rf_wdata = rd_val + imm_sext;
                    OP_LW, OP_SW: begin
                        rf_we    = 1'b0;
                        pc_d     = pc_q;
                        mem_load = 1'b1;
                        state_d  = ST_MEM;
                    end
                    OP_BEQ: begin
                        rf_we = 1'b0;
                        if (rd_val == rs1_val) pc_d = pc_q + br_off;
                    end
                    OP_BNE: begin
                        rf_we = 1'b0;
                        if (rd_val != rs1_val) pc_d = pc_q + br_off;
                    end
                    OP_JALR: begin
                        rf_wdata = DATA_WIDTH'(pc_inc);
                        pc_d     = ADDR_WIDTH'({rs1_val[DATA_WIDTH-1:1], 1'b0});
                    end
                    default: rf_we = 1'b0;
                endcase
            end

            ST_MEM: begin
                if (mem.dmem_ack) begin
                    state_d  = ST_FETCH;
                    pc_d     = pc_inc;
                    rf_we    = !dwe_q;
                    rf_wdata = mem.dmem_rdata;
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= ST_FETCH;
            pc_q     <= boot_addr_i;
            ir_q     <= '0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) ir_q <= fetch_half;
            if (mem_load) begin
                dwe_q    <= (op == OP_SW);
                daddr_q  <= ADDR_WIDTH'(eff_addr) & ~ADDR_WIDTH'(3);
                dwdata_q <= rd_val;
            end
        end
    end

    // NOTE: the register file is reset on purpose: the ISA defines r0..r15 = 0
    // after reset, and r0 relies on never leaving that value.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else if (rf_we && (rd != 4'd0)) begin
            rf_q[rd] <= rf_wdata;
        end
    end

    // Requests come straight from the state; reset forces everything quiet.
    assign mem.imem_req   = arst_ni && (state_q == ST_FETCH);
    assign mem.imem_addr  = mem.imem_req ? {pc_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem.dmem_req   = (state_q == ST_MEM);
    assign mem.dmem_we    = mem.dmem_req && dwe_q;
    assign mem.dmem_addr  = mem.dmem_req ? daddr_q : '0;
    assign mem.dmem_wdata = mem.dmem_req ? dwdata_q : '0;

endmodule

// File: tb/tb_simple_processor_core.sv
// Bench for simple_processor_core: memory responder with random wait states and
// an instruction-level reference model compared at every retirement.
module tb_simple_processor_core;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          arst_ni = 1'b0;
    logic [AW-1:0] boot_addr = 32'h1000;

    simple_processor_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    simple_processor_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .arst_ni    (arst_ni),
        .boot_addr_i(boot_addr),
        .mem        (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Shared 16 KB memory (addresses wrap) and the model's private copy.
    logic [31:0] tb_mem  [4096];
    logic [31:0] ref_mem [4096];

    task automatic put_half(input logic [31:0] addr, input logic [15:0] h);
        if (addr[1]) begin
            tb_mem[addr[13:2]][31:16]  = h;
            ref_mem[addr[13:2]][31:16] = h;
        end else begin
            tb_mem[addr[13:2]][15:0]  = h;
            ref_mem[addr[13:2]][15:0] = h;
        end
    endtask

    // Reference model: architectural state stepped one instruction at a time.
    logic [31:0] ref_pc;
    logic [31:0] ref_r [16];

    task automatic model_reset(input logic [31:0] boot);
        ref_pc = boot;
        for (int i = 0; i < 16; i++) ref_r[i] = 32'h0;
    endtask

    function automatic logic [15:0] model_insn();
        logic [31:0] w;
        w = ref_mem[ref_pc[13:2]];
        return ref_pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic model_step(output logic [3:0] op);
        logic [15:0] ins;
        logic [3:0]  rd, f1, f2;
        logic [31:0] a, b, d, imm, ea, nxt, res;
        logic        wr;
        ins = model_insn();
        op  = ins[15:12];
        rd  = ins[11:8];
        f1  = ins[7:4];
        f2  = ins[3:0];
        a   = ref_r[f1];
        b   = ref_r[f2];
        d   = ref_r[rd];
        imm = 32'($signed(ins[7:0]));
        ea  = a + b * 4;
        nxt = ref_pc + 2;
        wr  = 1'b1;
        res = 32'h0;
        case (op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = a << b[4:0];
            4'h6: res = a >> b[4:0];
            4'h7: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: res = imm;
            4'h9: res = d + imm;
            4'hA: res = ref_mem[ea[13:2]];
            4'hB: begin ref_mem[ea[13:2]] = d; wr = 1'b0; end
            4'hC: begin wr = 1'b0; if (d == a) nxt = ref_pc + 32'($signed(f2)) * 2; end
            4'hD: begin wr = 1'b0; if (d != a) nxt = ref_pc + 32'($signed(f2)) * 2; end
            4'hE: begin res = ref_pc + 2; nxt = {a[31:1], 1'b0}; end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 4'd0) ref_r[rd] = res;
        ref_pc = nxt;
    endtask

    // Memory responder: acks after 0..3 wait cycles, 1-cycle ack pulses.
    int fetch_limit = 0;
    int fetch_grants = 0;
    bit dmem_hold = 1'b0;
    int iw, dw;

    function automatic int rand_wait();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    initial begin
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!arst_ni) begin
                bus.imem_ack   = 1'b0;
                bus.dmem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                bus.dmem_rdata = $urandom;
                iw = rand_wait();
                dw = rand_wait();
                fetch_grants = 0;
            end else begin
                if (bus.imem_ack) begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = $urandom;
                    iw = rand_wait();
                end else if (bus.imem_req && fetch_grants < fetch_limit) begin
                    if (iw == 0) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = tb_mem[bus.imem_addr[13:2]];
                        fetch_grants++;
                    end else iw--;
                end
                if (bus.dmem_ack) begin
                    bus.dmem_ack   = 1'b0;
                    bus.dmem_rdata = $urandom;
                    dw = rand_wait();
                end else if (bus.dmem_req && !dmem_hold) begin
                    if (dw == 0) begin
                        bus.dmem_ack = 1'b1;
                        if (bus.dmem_we) tb_mem[bus.dmem_addr[13:2]] = bus.dmem_wdata;
                        else bus.dmem_rdata = tb_mem[bus.dmem_addr[13:2]];
                    end else dw--;
                end
            end
        end
    end

    // Compare process: a new fetch marks retirement of the previous instruction.
    int          retire_cnt = 0;
    bit          first = 1'b1;
    bit          prev_ireq = 1'b0, prev_dreq = 1'b0;
    logic [31:0] prev_iaddr, prev_daddr, prev_dwdata;
    logic        prev_dwe;
    int          cyc = 0, waits = 0;
    logic [3:0]  ret_op;

    initial forever begin
        @(negedge clk);
        if (!arst_ni) begin
            first = 1'b1; prev_ireq = 1'b0; prev_dreq = 1'b0;
            cyc = 0; waits = 0; retire_cnt = 0;
        end else begin
            check("req_exclusive", 32'(bus.imem_req && bus.dmem_req), 32'h0);
            if (bus.imem_req && !prev_ireq) begin
                if (!first) begin
                    model_step(ret_op);
                    retire_cnt++;
                    check("pc", dut.pc_q, ref_pc);
                    for (int i = 0; i < 16; i++)
                        check($sformatf("r%0d", i), dut.rf_q[i], ref_r[i]);
                    check("latency", 32'(cyc - waits),
                          (ret_op == 4'hA || ret_op == 4'hB) ? 32'd3 : 32'd2);
                end
                first = 1'b0; cyc = 0; waits = 0;
                check("fetch_addr", bus.imem_addr, {ref_pc[31:2], 2'b00});
            end else if (bus.imem_req) begin
                check("fetch_addr_stable", bus.imem_addr, prev_iaddr);
            end
            if (bus.dmem_req && !prev_dreq) begin
                logic [15:0] ins;
                logic [31:0] ea;
                ins = model_insn();
                ea  = ref_r[ins[7:4]] + ref_r[ins[3:0]] * 4;
                check("dmem_op", 32'(ins[15:12] == 4'hA || ins[15:12] == 4'hB), 32'h1);
                check("dmem_we", 32'(bus.dmem_we), 32'(ins[15:12] == 4'hB));
                check("dmem_addr", bus.dmem_addr, {ea[31:2], 2'b00});
                if (ins[15:12] == 4'hB) check("dmem_wdata", bus.dmem_wdata, ref_r[ins[11:8]]);
            end else if (bus.dmem_req) begin
                check("dmem_addr_stable", bus.dmem_addr, prev_daddr);
                check("dmem_wdata_stable", bus.dmem_wdata, prev_dwdata);
                check("dmem_we_stable", 32'(bus.dmem_we), 32'(prev_dwe));
            end else begin
                check("dmem_we_idle", 32'(bus.dmem_we), 32'h0);
            end
            if ((bus.imem_req && !bus.imem_ack) || (bus.dmem_req && !bus.dmem_ack)) waits++;
            cyc++;
            prev_ireq   = bus.imem_req;
            prev_iaddr  = bus.imem_addr;
            prev_dreq   = bus.dmem_req;
            prev_daddr  = bus.dmem_addr;
            prev_dwdata = bus.dmem_wdata;
            prev_dwe    = bus.dmem_we;
        end
    end

    task automatic wait_retire(input int n, input int budget);
        int c = 0;
        while (retire_cnt < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("retire_count", 32'(retire_cnt), 32'(n));
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        arst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Directed program at 0x1000, continuing at 0x40 after JALR.
        put_half(32'h1000, 16'h8105); // LI   r1,5
        put_half(32'h1002, 16'h82FD); // LI   r2,-3
        put_half(32'h1004, 16'h0312); // ADD  r3,r1,r2
        put_half(32'h1006, 16'h1412); // SUB  r4,r1,r2
        put_half(32'h1008, 16'h8540); // LI   r5,0x40
        put_half(32'h100A, 16'h8801); // LI   r8,1
        put_half(32'h100C, 16'hB158); // SW   r1,[r5+4*r8]
        put_half(32'h100E, 16'hA658); // LW   r6,[r5+4*r8]
        put_half(32'h1010, 16'hC125); // BEQ  r1,r2,+5 (not taken)
        put_half(32'h1012, 16'h8902); // LI   r9,2
        put_half(32'h1014, 16'hF000); // NOP
        put_half(32'h1016, 16'h99FF); // ADDI r9,-1
        put_half(32'h1018, 16'hD90E); // BNE  r9,r0,-2
        put_half(32'h101A, 16'h0011); // ADD  r0,r1,r1
        put_half(32'h101C, 16'hE750); // JALR r7,r5
        put_half(32'h0040, 16'h7A21); // SLT  r10,r2,r1
        put_half(32'h0042, 16'h5B18); // SLL  r11,r1,r8
        put_half(32'h0048, 16'h6C28); // SRL  r12,r2,r8
        put_half(32'h004A, 16'h4D12); // XOR  r13,r1,r2
        put_half(32'h004C, 16'h3E12); // OR   r14,r1,r2
        put_half(32'h004E, 16'h2F12); // AND  r15,r1,r2
        model_reset(32'h1000);

        repeat (3) @(negedge clk);
        check("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
        check("rst_dmem_we", 32'(bus.dmem_we), 32'h0);
        check("rst_dmem_addr", bus.dmem_addr, 32'h0);
        check("rst_dmem_wdata", bus.dmem_wdata, 32'h0);
        check("rst_pc", dut.pc_q, 32'h1000);

        fetch_limit = 26;
        release_reset();
        #1;
        check("first_imem_req", 32'(bus.imem_req), 32'h1);
        check("first_imem_addr", bus.imem_addr, 32'h1000);
        wait_retire(26, 600);

        check("lit_r0", dut.rf_q[0], 32'h0);
        check("lit_r1", dut.rf_q[1], 32'h5);
        check("lit_r2", dut.rf_q[2], 32'hFFFF_FFFD);
        check("lit_r3", dut.rf_q[3], 32'h2);
        check("lit_r4", dut.rf_q[4], 32'h8);
        check("lit_r6", dut.rf_q[6], 32'h5);
        check("lit_r7", dut.rf_q[7], 32'h101E);
        check("lit_r9", dut.rf_q[9], 32'h0);
        check("lit_r10", dut.rf_q[10], 32'h1);
        check("lit_r11", dut.rf_q[11], 32'hA);
        check("lit_r12", dut.rf_q[12], 32'h7FFF_FFFE);
        check("lit_r13", dut.rf_q[13], 32'hFFFF_FFF8);
        check("lit_r14", dut.rf_q[14], 32'hFFFF_FFFD);
        check("lit_r15", dut.rf_q[15], 32'h5);
        check("lit_mem44", tb_mem[32'h44 >> 2], 32'h5);
        check("lit_pc", dut.pc_q, 32'h50);
        check("lit_fetch50", bus.imem_addr, 32'h50);

        // Reset during a stalled load: no write-back, PC back to boot.
        arst_ni = 1'b0;
        boot_addr = 32'h2000;
        put_half(32'h2000, 16'h8110); // LI r1,0x10
        put_half(32'h2002, 16'hA210); // LW r2,[r1+4*r0]
        tb_mem[4]  = 32'hCAFE_0001;
        ref_mem[4] = 32'hCAFE_0001;
        model_reset(32'h2000);
        dmem_hold = 1'b1;
        fetch_limit = 2;
        repeat (2) @(negedge clk);
        release_reset();
        for (int c = 0; c < 60 && !bus.dmem_req; c++) @(negedge clk);
        check("mem_reached", 32'(bus.dmem_req), 32'h1);
        check("mem_addr_lit", bus.dmem_addr, 32'h10);
        check("mem_r1_lit", dut.rf_q[1], 32'h10);
        repeat (3) @(negedge clk);
        check("mem_still_req", 32'(bus.dmem_req), 32'h1);
        #2;
        arst_ni = 1'b0;
        #1;
        check("abort_dmem_req", 32'(bus.dmem_req), 32'h0);
        check("abort_dmem_addr", bus.dmem_addr, 32'h0);
        check("abort_imem_req", 32'(bus.imem_req), 32'h0);
        check("abort_pc", dut.pc_q, 32'h2000);
        check("abort_r2", dut.rf_q[2], 32'h0);
        dmem_hold = 1'b0;

        // Random program over the whole memory, checked by the model.
        boot_addr = $urandom & 32'h3FFE;
        for (int i = 0; i < 4096; i++) begin
            put_half(32'(i * 4), 16'($urandom));
            put_half(32'(i * 4 + 2), 16'($urandom));
        end
        model_reset(boot_addr);
        fetch_limit = 600;
        repeat (2) @(negedge clk);
        release_reset();
        wait_retire(600, 20000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
